// File: rtl/mux8_scan_ctrl.sv
// Scan controller for an 8:1 mux: steps the select 0..7, samples mux_f after a settle time,
// and presents the packed byte with a valid/ready handshake. Optional parity: MUX_SCAN_PARITY_EN.
module mux8_scan_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_f,
    output logic [2:0] mux_sel,
    output logic       busy,
    output logic [7:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       start_ignored,
    output logic       parity_out,
    output logic [1:0] dbg_state
);

    // Handshake: a word transfers on any rising edge where word_valid and word_ready are both 1;
    // word_out/word_valid stay stable until then, and word_valid drops on that edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);
    localparam logic [2:0] LAST_CH     = 3'(NUM_CH - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] sel_d;
    logic [7:0] word_d;
    logic       valid_d;
    logic       ign_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = mux_sel;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_out;
        valid_d = word_valid;
        ign_d   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                cnt_d = 4'd0;
                if (start) state_d = SCAN;
            end
            SCAN: begin
                ign_d = start;
                if (cnt_q == SETTLE_LAST) begin
                    shift_d[mux_sel] = mux_f;
                    cnt_d            = 4'd0;
                    sel_d            = mux_sel + 3'd1;
                    // Last channel: publish the word including the bit captured this edge.
                    if (mux_sel == LAST_CH) begin
                        word_d  = shift_d;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    sel_d   = 3'd0;
                    cnt_d   = 4'd0;
                    state_d = start ? SCAN : IDLE;
                end else begin
                    ign_d = start;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_sel       <= 3'd0;
            cnt_q         <= 4'd0;
            shift_q       <= 8'h00;
            word_out      <= 8'h00;
            word_valid    <= 1'b0;
            start_ignored <= 1'b0;
        end else begin
            mux_sel       <= sel_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            word_out      <= word_d;
            word_valid    <= valid_d;
            start_ignored <= ign_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk) begin
        if (!rst_n) parity_q <= 1'b0;
        else        parity_q <= ^word_d;
    end
    assign parity_out = parity_q;
`else
    assign parity_out = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
